riscv_core: RTL and testbench

Single-cycle RV64I integer core with built-in instruction memory, data memory and register file: one instruction is fetched, decoded, executed and retired every clock. It is the top of the processor and has only clock and reset pins; programs and data are preloaded into its memories and the register file, and results are read back from those arrays. Sub-instances are `u_riscv_core_imem` (array `mem`), `u_riscv_core_data_mem` (array `mem`) and `u_riscv_core_rf` (array `rf`), so those paths are fixed.

---
 rtl/riscv_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_riscv_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_core.sv
// riscv_core: single-cycle RV64I core with built-in instruction memory, data memory and
// register file. Every rising edge with rst_n high retires one instruction: the rd write,
// any store and the PC update all land on that edge. Fetch, decode, execute and the
// data-memory read are purely combinational.
//
// Ports:
//   clk    core clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset; forces PC to 0 and suppresses all writes
//
// Storage (fixed hierarchical paths, preloaded and inspected from outside):
//   u_riscv_core_imem.mem      IMEM_BYTES x 8, little-endian, read-only in hardware
//   u_riscv_core_data_mem.mem  DMEM_BYTES x 8, little-endian, any alignment
//   u_riscv_core_rf.rf         32 x XLEN, x0 reads as zero

module riscv_core #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned IMEM_BYTES = 1024,
    parameter int unsigned DMEM_BYTES = 1024
) (
    input logic clk,
    input logic rst_n
);

    localparam int unsigned ImemAw = $clog2(IMEM_BYTES);
    localparam int unsigned DmemAw = $clog2(DMEM_BYTES);

    typedef enum logic [6:0] {
        OpLui     = 7'b0110111,
        OpAuipc   = 7'b0010111,
        OpJal     = 7'b1101111,
        OpJalr    = 7'b1100111,
        OpBranch  = 7'b1100011,
        OpLoad    = 7'b0000011,
        OpStore   = 7'b0100011,
        OpImm     = 7'b0010011,
        OpReg     = 7'b0110011,
        OpImm32   = 7'b0011011,
        OpReg32   = 7'b0111011
    } opcode_e;

    // Power-up value covers the case where rst_n never sees a rising edge.
    logic [XLEN-1:0] pc_q = '0;
    logic [XLEN-1:0] pc_d;

    logic [31:0]      insn;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    logic             rf_we;
    logic [XLEN-1:0]  rf_wdata;
    logic             st_en;
    logic [3:0]       st_nbytes;
    logic [DmemAw-1:0] daddr;
    logic [XLEN-1:0]  ld_raw;

    wire [6:0] opcode = insn[6:0];
    wire [4:0] rd     = insn[11:7];
    wire [2:0] funct3 = insn[14:12];
    wire [4:0] rs1    = insn[19:15];
    wire [4:0] rs2    = insn[24:20];
    wire [6:0] funct7 = insn[31:25];

    wire [XLEN-1:0] imm_i = {{(XLEN-12){insn[31]}}, insn[31:20]};
    wire [XLEN-1:0] imm_s = {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
    wire [XLEN-1:0] imm_b = {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25],
                             insn[11:8], 1'b0};
    wire [XLEN-1:0] imm_u = {{(XLEN-32){insn[31]}}, insn[31:12], 12'b0};
    wire [XLEN-1:0] imm_j = {{(XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20],
                             insn[30:21], 1'b0};

    // ---------------------------------------------------------------- instruction memory
    if (1'b1) begin : u_riscv_core_imem
        localparam bit ImemWe = 1'b0;
        logic [7:0]        mem [IMEM_BYTES];
        logic [ImemAw-1:0] a0, a1, a2, a3;

        always_comb begin
            a0   = pc_q[ImemAw-1:0];
            a1   = a0 + ImemAw'(1);
            a2   = a0 + ImemAw'(2);
            a3   = a0 + ImemAw'(3);
            insn = {mem[a3], mem[a2], mem[a1], mem[a0]};
        end

        // No write port exists; this never-enabled port only anchors the array as state.
        always_ff @(posedge clk) begin
            if (ImemWe) begin
                mem[0] <= 8'h00;
            end
        end
    end

    // ---------------------------------------------------------------- register file
    if (1'b1) begin : u_riscv_core_rf
        logic [XLEN-1:0] rf [32];

        assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
        assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

        always_ff @(posedge clk) begin
            if (rst_n && rf_we && (rd != 5'd0)) begin
                rf[rd] <= rf_wdata;
            end
        end
    end

    // ---------------------------------------------------------------- data memory
    if (1'b1) begin : u_riscv_core_data_mem
        logic [7:0] mem [DMEM_BYTES];

        // Byte addresses wrap inside the array, so unaligned accesses at the top wrap to 0.
        always_comb begin
            ld_raw = '0;
            for (int k = 0; k < 8; k++) begin
                ld_raw[8*k +: 8] = mem[daddr + DmemAw'(k)];
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n && st_en) begin
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < st_nbytes) begin
                        mem[daddr + DmemAw'(k)] <= rs2_val[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------------------------------------------------------- execute helpers
    function automatic logic [XLEN-1:0] alu_full(input logic [2:0] f3, input logic alt,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        r = '0;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[5:0];
            3'b010:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011:  r = {{(XLEN-1){1'b0}}, a < b};
            3'b100:  r = a ^ b;
            3'b101: begin
                // Kept as separate assignments so the arithmetic shift stays signed.
                if (alt) r = $signed(a) >>> b[5:0];
                else     r = a >> b[5:0];
            end
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] alu_word(input logic [2:0] f3, input logic alt,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'b001: r = a << b[4:0];
            3'b101: begin
                if (alt) r = $signed(a) >>> b[4:0];
                else     r = a >> b[4:0];
            end
            default: r = alt ? (a - b) : (a + b);
        endcase
        return {{(XLEN-32){r[31]}}, r};
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  r = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b010:  r = {{(XLEN-32){raw[31]}}, raw[31:0]};
            3'b100:  r = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}}, raw[15:0]};
            3'b110:  r = {{(XLEN-32){1'b0}}, raw[31:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- decode / next state
    logic br_taken;
    logic alt_imm;

    always_comb begin
        pc_d      = pc_q + XLEN'(4);
        rf_we     = 1'b0;
        rf_wdata  = '0;
        st_en     = 1'b0;
        st_nbytes = 4'd0;
        daddr     = DmemAw'(rs1_val + ((opcode == OpStore) ? imm_s : imm_i));
        alt_imm   = (funct3 == 3'b101) && insn[30];

        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val < rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;  // 010/011 are not branches
        endcase

        case (opcode_e'(opcode))
            OpLui: begin
                rf_we    = 1'b1;
                rf_wdata = imm_u;
            end
            OpAuipc: begin
                rf_we    = 1'b1;
                rf_wdata = pc_q + imm_u;
            end
            OpJal: begin
                rf_we    = 1'b1;
                rf_wdata = pc_q + XLEN'(4);
                pc_d     = pc_q + imm_j;
            end
            OpJalr: begin
                if (funct3 == 3'b000) begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_q + XLEN'(4);
                    pc_d     = (rs1_val + imm_i) & ~XLEN'(1);
                end
            end
            OpBranch: begin
                if (br_taken) pc_d = pc_q + imm_b;
            end
            OpLoad: begin
                if (funct3 != 3'b111) begin
                    rf_we    = 1'b1;
                    rf_wdata = load_ext(funct3, ld_raw);
                end
            end
            OpStore: begin
                if (!funct3[2]) begin
                    st_en     = 1'b1;
                    st_nbytes = 4'd1 << funct3[1:0];
                end
            end
            OpImm: begin
                if ((funct3 == 3'b001 && insn[31:26] == 6'b000000) ||
                    (funct3 == 3'b101 && (insn[31:26] == 6'b000000 ||
                                          insn[31:26] == 6'b010000)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_full(funct3, alt_imm, rs1_val, imm_i);
                end
            end
            OpReg: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_full(funct3, insn[30], rs1_val, rs2_val);
                end
            end
            OpImm32: begin
                if (funct3 == 3'b000 ||
                    (funct3 == 3'b001 && funct7 == 7'b0000000) ||
                    (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)))
                begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_word(funct3, alt_imm, rs1_val[31:0], imm_i[31:0]);
                end
            end
            OpReg32: begin
                if (((funct3 == 3'b000 || funct3 == 3'b101) &&
                     (funct7 == 7'b0000000 || funct7 == 7'b0100000)) ||
                    (funct3 == 3'b001 && funct7 == 7'b0000000)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_word(funct3, insn[30], rs1_val[31:0], rs2_val[31:0]);
                end
            end
            default: ;  // FENCE, SYSTEM and unknown encodings retire as NOP
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_riscv_core.sv
// Directed bench for riscv_core: preloads memories and register file through the fixed
// hierarchical paths, retires instructions one edge at a time and compares architectural
// state against hand-computed values on the following falling edge.

module tb_riscv_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_core u_dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    task automatic put_insn(input int addr, input logic [31:0] w);
        for (int b = 0; b < 4; b++) u_dut.u_riscv_core_imem.mem[addr + b] = w[8*b +: 8];
    endtask

    // Fill imem with ADDI x0,x0,0, clear dmem, set rf[i] = 2i.
    task automatic clear_all();
        for (int a = 0; a < 1024; a += 4) put_insn(a, 32'h0000_0013);
        for (int a = 0; a < 1024; a++) u_dut.u_riscv_core_data_mem.mem[a] = 8'h00;
        for (int r = 0; r < 32; r++) u_dut.u_riscv_core_rf.rf[r] = 64'(2 * r);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic core_reset(input int edges);
        rst_n = 1'b0;
        repeat (edges) step();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] xr(input int r);
        return u_dut.u_riscv_core_rf.rf[r];
    endfunction

    function automatic logic [63:0] dm(input int a);
        return {56'h0, u_dut.u_riscv_core_data_mem.mem[a]};
    endfunction

    function automatic logic [63:0] dm64(input int a);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[8*b +: 8] = u_dut.u_riscv_core_data_mem.mem[a + b];
        return v;
    endfunction

    initial begin
        @(negedge clk);

        // ---- load word
        clear_all();
        for (int a = 0; a < 50; a++) u_dut.u_riscv_core_data_mem.mem[a] = 8'(a);
        put_insn(0, enc_i(0, 0, 3'b010, 17, OP_LOAD));
        put_insn(4, enc_i(4, 0, 3'b010, 17, OP_LOAD));
        put_insn(8, enc_i(8, 0, 3'b010, 17, OP_LOAD));
        core_reset(1);
        check_eq("reset_pc", u_dut.pc_q, 64'd0);
        check_eq("reset_keeps_x17", xr(17), 64'd34);
        step(); check_eq("lw0", xr(17), 64'h0000_0000_0302_0100);
        step(); check_eq("lw4", xr(17), 64'h0000_0000_0706_0504);
        step(); check_eq("lw8", xr(17), 64'h0000_0000_0B0A_0908);

        // ---- load sign extension
        clear_all();
        u_dut.u_riscv_core_data_mem.mem[19] = 8'h80;
        put_insn(0, enc_i(16, 0, 3'b010, 17, OP_LOAD));
        put_insn(4, enc_i(16, 0, 3'b110, 18, OP_LOAD));
        put_insn(8, enc_i(16, 0, 3'b001, 19, OP_LOAD));
        core_reset(1);
        step(); check_eq("lw_sext", xr(17), 64'hFFFF_FFFF_8000_0000);
        step(); check_eq("lwu_zext", xr(18), 64'h0000_0000_8000_0000);
        step(); check_eq("lh_low_half", xr(19), 64'h0000_0000_0000_0000);

        // ---- store then load
        clear_all();
        u_dut.u_riscv_core_rf.rf[5] = 64'h1122_3344_5566_7788;
        u_dut.u_riscv_core_data_mem.mem[31] = 8'h3C;
        u_dut.u_riscv_core_data_mem.mem[41] = 8'hA5;
        put_insn(0, enc_s(32, 5, 0, 3'b011));
        put_insn(4, enc_i(32, 0, 3'b011, 17, OP_LOAD));
        put_insn(8, enc_s(40, 5, 0, 3'b000));
        core_reset(1);
        step(); check_eq("sd_bytes", dm64(32), 64'h1122_3344_5566_7788);
        check_eq("sd_below_untouched", dm(31), 64'h3C);
        step(); check_eq("ld_after_sd", xr(17), 64'h1122_3344_5566_7788);
        step(); check_eq("sb_byte", dm(40), 64'h88);
        check_eq("sb_above_untouched", dm(41), 64'hA5);
        check_eq("sb_below_untouched", dm(39), 64'h11);

        // ---- ALU and x0
        clear_all();
        u_dut.u_riscv_core_rf.rf[31] = 64'h0000_0000_7FFF_FFFF;
        put_insn(0,  enc_r(7'b0000000, 4, 3, 3'b000, 17, OP_REG));
        put_insn(4,  enc_i(5, 0, 3'b000, 0, OP_IMM));
        put_insn(8,  enc_r(7'b0000000, 31, 31, 3'b000, 18, OP_REG32));
        put_insn(12, enc_r(7'b0100000, 4, 3, 3'b000, 19, OP_REG));
        put_insn(16, enc_i(32'h401, 19, 3'b101, 20, OP_IMM));
        put_insn(20, enc_i(60, 19, 3'b101, 21, OP_IMM));
        put_insn(24, enc_i(1, 31, 3'b001, 22, OP_IMM32));
        core_reset(1);
        step(); check_eq("add", xr(17), 64'd14);
        step(); check_eq("x0_stays_zero", xr(0), 64'd0);
        step(); check_eq("addw_sext", xr(18), 64'hFFFF_FFFF_FFFF_FFFE);
        step(); check_eq("sub", xr(19), 64'hFFFF_FFFF_FFFF_FFFE);
        step(); check_eq("srai", xr(20), 64'hFFFF_FFFF_FFFF_FFFF);
        step(); check_eq("srli_shamt60", xr(21), 64'h0000_0000_0000_000F);
        step(); check_eq("slliw_sext", xr(22), 64'hFFFF_FFFF_FFFF_FFFE);

        // ---- control flow
        clear_all();
        put_insn(0,  enc_b(8, 0, 0, 3'b000));
        put_insn(4,  enc_i(21, 0, 3'b000, 2, OP_JALR));
        put_insn(8,  enc_j(32'hFFFF_FFFC, 1));
        put_insn(20, enc_b(32'hFFFF_FFEC, 0, 0, 3'b001));
        core_reset(1);
        step(); check_eq("beq_pc", u_dut.pc_q, 64'd8);
        step(); check_eq("jal_pc", u_dut.pc_q, 64'd4);
        check_eq("jal_link", xr(1), 64'd12);
        step(); check_eq("jalr_pc_lsb_clear", u_dut.pc_q, 64'd20);
        check_eq("jalr_link", xr(2), 64'd8);
        step(); check_eq("bne_not_taken_pc", u_dut.pc_q, 64'd24);

        // ---- reset mid-program
        clear_all();
        u_dut.u_riscv_core_rf.rf[9] = 64'd0;
        u_dut.u_riscv_core_data_mem.mem[48] = 8'h5A;
        put_insn(0,  enc_i(1, 9, 3'b000, 9, OP_IMM));
        put_insn(4,  enc_i(1, 9, 3'b000, 9, OP_IMM));
        put_insn(8,  enc_i(1, 9, 3'b000, 9, OP_IMM));
        put_insn(12, enc_s(48, 9, 0, 3'b000));
        core_reset(1);
        repeat (3) step();
        check_eq("pre_reset_x9", xr(9), 64'd3);
        check_eq("pre_reset_pc", u_dut.pc_q, 64'd12);
        core_reset(2);
        check_eq("mid_reset_pc", u_dut.pc_q, 64'd0);
        check_eq("mid_reset_x9", xr(9), 64'd3);
        check_eq("mid_reset_no_store", dm(48), 64'h5A);
        step(); check_eq("resume_x9", xr(9), 64'd4);
        check_eq("resume_pc", u_dut.pc_q, 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
